// File: rtl/irq_defs_pkg.sv
// Shared constants and FSM encoding for the interrupt request front-end.
// Pure definitions: no logic, no latency, no backpressure.
package irq_defs;

    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/priority_encoder.sv
// 8:3 priority encoder; the highest set bit wins.
// Purely combinational (zero latency); no backpressure.
module priority_encoder
    import irq_defs::*;
(
    input  logic [N_IRQ-1:0] in,
    output logic [ID_W-1:0]  out,
    output logic             valid
);

    // Scan upward so the last (highest) set bit overwrites the lower ones.
    always_comb begin
        out = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (in[i]) begin
                out = ID_W'(i);
            end
        end
    end

    assign valid = |in;

endmodule

// File: rtl/irq_request_ctrl.sv
// Edge-detected sticky interrupt pending bits, masked arbitration, valid/ack grant.
// Latency: irq edge to req_valid is 2 cycles; one bubble cycle between grants.
// Backpressure: a presented request is held stable until req_ack or clear_all.
module irq_request_ctrl
    import irq_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             req_ack,
    input  logic             clear_all,
    output logic             req_valid,
    output logic [ID_W-1:0]  req_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] overflow
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   req_id_nxt;
    logic [N_IRQ-1:0]  irq_prev;
    logic [N_IRQ-1:0]  evt;
    logic [N_IRQ-1:0]  ack_clr;
    logic              ack_fire;
    logic [N_IRQ-1:0]  enc_in;
    logic [ID_W-1:0]   enc_out;
    logic              enc_valid;

    assign evt      = irq_in & ~irq_prev;
    assign ack_fire = (state == REQ) && req_ack && !clear_all;
    assign ack_clr  = ack_fire ? (N_IRQ'(1) << req_id) : '0;
    assign enc_in   = pending & irq_mask;

    priority_encoder u_prio_enc (
        .in    (enc_in),
        .out   (enc_out),
        .valid (enc_valid)
    );

    // A fresh event outranks the ack-clear of the same bit so nothing is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= irq_in;
            pending  <= '0;
            overflow <= '0;
        end else begin
            irq_prev <= irq_in;
            if (clear_all) begin
                pending  <= '0;
                overflow <= '0;
            end else begin
                pending  <= (pending & ~ack_clr) | evt;
                overflow <= overflow | (evt & pending & ~ack_clr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req_id <= '0;
        end else begin
            state  <= state_nxt;
            req_id <= req_id_nxt;
        end
    end

    // No pre-emption: once in REQ, req_id only changes after returning to IDLE.
    always_comb begin
        state_nxt  = state;
        req_id_nxt = req_id;
        if (clear_all) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state_nxt  = REQ;
                        req_id_nxt = enc_out;
                    end
                end
                REQ: begin
                    if (req_ack) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign req_valid = (state == REQ);

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Scoreboard bench for irq_request_ctrl: expected grant ids are queued at stimulus
// time and popped as the DUT presents requests.
module tb_irq_request_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic [7:0] irq_mask;
    logic       req_ack;
    logic       clear_all;
    logic       req_valid;
    logic [2:0] req_id;
    logic [7:0] pending;
    logic [7:0] overflow;

    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    logic [2:0] exp_q[$];

    irq_request_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .irq_mask  (irq_mask),
        .req_ack   (req_ack),
        .clear_all (clear_all),
        .req_valid (req_valid),
        .req_id    (req_id),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Ack every presented request, checking id against the scoreboard and the
    // 2-cycle spacing between consecutive grants.
    task automatic serve(input int n, input int budget);
        int got  = 0;
        int last = -1;
        int t    = 0;
        logic [2:0] e;
        while (got < n && t < budget) begin
            if (req_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("grant_id", 32'(req_id), 32'(e));
                end else begin
                    chk("sb_unexpected_grant", 32'(req_id), 32'hFFFF);
                end
                if (last >= 0) chk("grant_gap", cyc - last, 2);
                last    = cyc;
                got++;
                req_ack = 1'b1;
            end else begin
                req_ack = 1'b0;
            end
            step();
            t++;
        end
        req_ack = 1'b0;
        if (got < n) chk("grant_timeout", got, n);
    endtask

    task automatic pulse(input logic [7:0] lines);
        irq_in = lines;
        step();
        irq_in = 8'h00;
    endtask

    initial begin
        rst       = 1'b1;
        irq_in    = 8'hFF;
        irq_mask  = 8'hFF;
        req_ack   = 1'b0;
        clear_all = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;

        // Lines held high through reset are not events.
        for (int i = 0; i < 10; i++) begin
            chk("rst_hold_valid", 32'(req_valid), 0);
            step();
        end
        chk("rst_pending", 32'(pending), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_req_id", 32'(req_id), 0);
        irq_in = 8'h00;
        step();

        // Single event on line 3.
        pulse(8'h08);
        chk("l3_pending", 32'(pending), 32'h08);
        chk("l3_valid_early", 32'(req_valid), 0);
        step();
        chk("l3_valid", 32'(req_valid), 1);
        exp_q.push_back(3'd3);
        serve(1, 10);
        chk("l3_pending_after", 32'(pending), 0);
        chk("l3_valid_after", 32'(req_valid), 0);

        // Three simultaneous lines, granted highest first.
        pulse(8'hA2);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd1);
        serve(3, 20);
        chk("multi_pending", 32'(pending), 0);

        // Masked line stays pending; acks in IDLE are ignored.
        irq_mask = 8'h7F;
        pulse(8'h80);
        req_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        req_ack = 1'b0;
        chk("mask_valid", 32'(req_valid), 0);
        chk("mask_pending", 32'(pending), 32'h80);
        irq_mask = 8'hFF;
        exp_q.push_back(3'd7);
        serve(1, 10);
        chk("unmask_pending", 32'(pending), 0);

        // Event coincident with ack of the same line is kept, not an overflow.
        pulse(8'h04);
        step();
        chk("l2_valid", 32'(req_valid), 1);
        chk("l2_id", 32'(req_id), 2);
        req_ack = 1'b1;
        irq_in  = 8'h04;
        step();
        req_ack = 1'b0;
        irq_in  = 8'h00;
        chk("l2_repend", 32'(pending), 32'h04);
        chk("l2_no_ovf", 32'(overflow), 0);
        chk("l2_bubble", 32'(req_valid), 0);
        step();
        chk("l2_represent", 32'(req_valid), 1);
        chk("l2_represent_id", 32'(req_id), 2);
        pulse(8'h04);
        chk("l2_overflow", 32'(overflow), 32'h04);
        chk("l2_still_valid", 32'(req_valid), 1);
        exp_q.push_back(3'd2);
        serve(1, 10);
        chk("l2_pending_after", 32'(pending), 0);

        // clear_all overrides a same-cycle ack and flushes everything.
        pulse(8'h12);
        step();
        chk("clr_valid", 32'(req_valid), 1);
        chk("clr_id", 32'(req_id), 4);
        clear_all = 1'b1;
        req_ack   = 1'b1;
        step();
        clear_all = 1'b0;
        req_ack   = 1'b0;
        chk("clr_pending", 32'(pending), 0);
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_valid_after", 32'(req_valid), 0);
        for (int i = 0; i < 5; i++) begin
            chk("clr_no_grant", 32'(req_valid), 0);
            step();
        end

        // Reset during REQ aborts the request.
        pulse(8'h40);
        step();
        chk("rstreq_valid", 32'(req_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstreq_valid_after", 32'(req_valid), 0);
        chk("rstreq_pending", 32'(pending), 0);
        step();
        chk("rstreq_idle", 32'(req_valid), 0);

        chk("sb_leftover", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/irq_request_ctrl.md
Name: irq_request_ctrl

Overview:
- Interrupt request front-end that sits directly upstream of the 8:3 priority_encoder.
- Detects rising edges on 8 request lines and latches them as sticky pending bits.
- Applies an enable mask and feeds the masked pending vector to priority_encoder.
- Presents the winning index to the consumer over a valid/ack handshake, then clears that pending bit on acknowledge.

Parameters:
- N_IRQ, 8, number of request lines. Fixed at 8 to match the priority_encoder width.
- ID_W, 3, width of the request index. Equals log2(N_IRQ).

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  8  level request lines in the clk domain. A 0->1 transition is one event.
- irq_mask  input  8  1 = line enabled for arbitration. Masked lines still latch pending.
- req_ack  input  1  consumer accepts the current request. Meaningful only while req_valid=1.
- clear_all  input  1  synchronous flush of pending, overflow and handshake state.
- req_valid  output  1  a request is being presented.
- req_id  output  3  index of the presented request. Bit 7 is highest priority.
- pending  output  8  sticky pending bits, unmasked, for status readback.
- overflow  output  8  sticky per-line flag: an event arrived while that line was already pending.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, overflow=0, req_valid=0, req_id=0, state=IDLE.
  - irq_prev loads irq_in, so a line held high through reset is not an event.
- Edge detect:
  - evt[i] = irq_in[i] & ~irq_prev[i].
  - irq_prev <= irq_in every non-reset cycle.
- Pending update priority, per bit:
  - clear_all -> 0.
  - Otherwise, evt -> 1. An event coincident with an ack-clear of the same bit wins, so no event is lost.
  - Otherwise, ack-clear of req_id -> 0.
  - Otherwise, hold.
- Overflow:
  - overflow[i] <= 1 when evt[i] and pending[i] are already 1 and no ack-clear of bit i occurs in that cycle.
  - Cleared only by clear_all or rst.
- Arbitration:
  - enc_in = pending & irq_mask, driven combinationally into the priority_encoder instance.
  - enc_valid = |enc_in.
  - Encoder output: index of the highest set bit.
- FSM, two states:
  - IDLE: req_valid=0. If enc_valid, capture req_id <= enc_out and go to REQ.
  - REQ: req_valid=1. req_id stays stable even if the mask or pending bits change. A higher-priority arrival does not pre-empt a presented request. On req_ack: clear pending[req_id] and go to IDLE.
  - clear_all in any state: go to IDLE and drop req_valid=0 on the next cycle. clear_all overrides req_ack in the same cycle.
- Latency:
  - irq_in rises before edge k -> pending set after edge k -> req_valid=1 after edge k+1 (2 cycles).
  - Ack at edge m -> req_valid=0 after m. The next request is presented after m+1, so there is a one-cycle bubble between grants.
- Boundary cases:
  - req_ack while in IDLE is ignored.
  - Masked-only pending bits keep the FSM in IDLE, and those bits stay pending.
  - Unmasking a pending line makes it eligible in the next IDLE cycle.
  - All 8 lines pending: grants go 7,6,...,0, one every 2 cycles under continuous ack.
  - rst during REQ aborts the request with no clear of pending beyond the reset itself.

Decomposition:
- Shared package/header irq_defs:
  - N_IRQ and ID_W constants.
  - FSM state encodings: IDLE=1'b0, REQ=1'b1.
- Sub-module: priority_encoder, the existing 8:3 block (in/out/valid), instantiated once on enc_in.
- Edge detect, pending/overflow registers and the FSM stay inline.

Test Plan:
- Reset with irq_in=8'hFF held, then release and hold -> pending=0, req_valid stays 0 for 10 cycles.
- Pulse irq_in[3] for 1 cycle, mask=8'hFF -> pending=8'h08 one cycle later, then req_valid=1 with req_id=3. Ack for 1 cycle -> pending=0, req_valid=0.
- Raise irq_in[1], [5], [7] together, mask=8'hFF, ack every cycle that req_valid=1 -> grants 7, 5, 1 at 2-cycle spacing, final pending=0.
- mask=8'h7F, event on line 7 -> no req_valid, pending=8'h80. Set mask=8'hFF -> req_id=7 presented.
- Line 2 pending and presented; while in REQ, a new edge on line 2 arrives in the same cycle as req_ack -> pending[2] stays 1, overflow[2]=0, line 2 re-presented after the bubble. A second edge on line 2 while still pending and not acked -> overflow=8'h04.
- In REQ with req_id=4, assert clear_all and req_ack together -> pending=0, overflow=0, req_valid=0 next cycle, no further grants.
